// File: rtl/trap_csr_if.sv
// trap_csr_if: bundles the EX-stage instruction/CSR signals and the trap
// unit's responses. The master modport is the pipeline, the slave modport is
// trap_csr_unit.
//
// Handshake: ex_valid qualifies every ex_* and csr_* field in the same cycle;
// there is no ready/back-pressure. The unit answers combinationally with
// kill_ex/csr_rdata. trap_redirect is a single-cycle pulse, and redirect_pc
// is meaningful only while it is high. The pipeline must accept it
// unconditionally.
interface trap_csr_if #(
  parameter int XLEN    = 32,
  parameter int CAUSE_W = 8
);
  logic               ex_valid;
  logic [XLEN-1:0]    ex_pc;
  logic [CAUSE_W-1:0] ex_cause;
  logic               ex_mret;
  logic [1:0]         csr_op;
  logic [11:0]        csr_addr;
  logic [XLEN-1:0]    csr_wdata;
  logic [XLEN-1:0]    csr_rdata;
  logic               kill_ex;
  logic               trap_redirect;
  logic [XLEN-1:0]    redirect_pc;
  logic               in_handler;
  logic [1:0]         state_dbg;

  modport master (
    output ex_valid, ex_pc, ex_cause, ex_mret, csr_op, csr_addr, csr_wdata,
    input  csr_rdata, kill_ex, trap_redirect, redirect_pc, in_handler, state_dbg
  );

  modport slave (
    input  ex_valid, ex_pc, ex_cause, ex_mret, csr_op, csr_addr, csr_wdata,
    output csr_rdata, kill_ex, trap_redirect, redirect_pc, in_handler, state_dbg
  );
endinterface

// File: rtl/trap_csr_unit.sv
// trap_csr_unit: supervisor-style trap/CSR unit beside the EX stage.
// Latches edge-triggered interrupts and owns sstatus, sie, sip, stvec, sepc
// and scause. It arbitrates sync exceptions, interrupts and MRET, and issues
// a registered one-cycle PC redirect.
// Optional macro VECTORED_TVEC_EN: makes stvec[1:0] writable. With mode 01,
// interrupts are vectored to base + 4*(16+i).
module trap_csr_unit #(
  parameter int          XLEN       = 32,
  parameter int          NUM_IRQ    = 4,
  parameter int          CAUSE_W    = 8,
  parameter logic [31:0] TVEC_RESET = 32'h0000_0100
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  trap_csr_if.slave          bus
);

  localparam logic [11:0] A_SSTATUS = 12'h100;
  localparam logic [11:0] A_SIE     = 12'h104;
  localparam logic [11:0] A_SIP     = 12'h144;
  localparam logic [11:0] A_STVEC   = 12'h105;
  localparam logic [11:0] A_SEPC    = 12'h141;
  localparam logic [11:0] A_SCAUSE  = 12'h142;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_HANDLER  = 2'd2
  } state_t;

  state_t             state;
  logic               ret_flag;
  logic               ie, pie;
  logic [NUM_IRQ-1:0] sie, sip, irq_q;
  logic [XLEN-1:0]    stvec, sepc, scause;
  logic [XLEN-1:0]    redirect_pc_q;
  logic               redirect_q;

  logic               sync_trap, irq_take, mret_take, kill, csr_we;
  logic [NUM_IRQ-1:0] pend, irq_onehot, sip_clr;
  logic [4:0]         irq_idx;
  logic [XLEN-1:0]    rdata, wr_val, tvec_base, trap_target;

  // Trap/MRET decision for the instruction currently in EX.
  always_comb begin
    pend      = sip & sie;
    sync_trap = bus.ex_valid && (bus.ex_cause != '0) && (state != ST_REDIRECT);
    irq_take  = (state == ST_RUN) && bus.ex_valid && (bus.ex_cause == '0) &&
                ie && (|pend);
    mret_take = (state == ST_HANDLER) && bus.ex_valid && bus.ex_mret && !sync_trap;
    // Anything in EX during the redirect cycle is wrong-path.
    kill      = sync_trap || irq_take || ((state == ST_REDIRECT) && bus.ex_valid);
    csr_we    = bus.ex_valid && !kill && !mret_take && (bus.csr_op != 2'b00);
  end

  // Fixed priority: the lowest-numbered pending enabled line wins.
  always_comb begin
    irq_idx = 5'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pend[i]) irq_idx = 5'(i);
    end
    irq_onehot = NUM_IRQ'(1) << irq_idx;
  end

  // Old-value CSR read, then the RW/RS/RC result built from it.
  always_comb begin
    rdata = '0;
    case (bus.csr_addr)
      A_SSTATUS: rdata = XLEN'({pie, ie});
      A_SIE:     rdata = XLEN'(sie);
      A_SIP:     rdata = XLEN'(sip);
      A_STVEC:   rdata = stvec;
      A_SEPC:    rdata = sepc;
      A_SCAUSE:  rdata = scause;
      default:   rdata = '0;
    endcase
    case (bus.csr_op)
      2'b01:   wr_val = bus.csr_wdata;
      2'b10:   wr_val = rdata | bus.csr_wdata;
      2'b11:   wr_val = rdata & ~bus.csr_wdata;
      default: wr_val = rdata;
    endcase
  end

  // sip bits drop when their interrupt is taken or when RC-cleared by software.
  always_comb begin
    sip_clr = '0;
    if (irq_take) sip_clr = sip_clr | irq_onehot;
    if (csr_we && (bus.csr_addr == A_SIP) && (bus.csr_op == 2'b11))
      sip_clr = sip_clr | bus.csr_wdata[NUM_IRQ-1:0];
  end

  // Trap target: base address, optionally vectored for interrupts.
  always_comb begin
    tvec_base = {stvec[XLEN-1:2], 2'b00};
`ifdef VECTORED_TVEC_EN
    if (irq_take && (stvec[1:0] == 2'b01))
      trap_target = tvec_base + {{(XLEN-7){1'b0}}, irq_idx + 5'd16, 2'b00};
    else
      trap_target = tvec_base;
`else
    trap_target = tvec_base;
`endif
  end

  // Interrupt edge capture; a new edge wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q <= '0;
      sip   <= '0;
    end else begin
      irq_q <= irq_in;
      sip   <= (sip & ~sip_clr) | (irq_in & ~irq_q);
    end
  end

  // Trap FSM together with the CSR registers it shares with software writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_RUN;
      ret_flag      <= 1'b0;
      ie            <= 1'b0;
      pie           <= 1'b0;
      sie           <= '0;
      stvec         <= XLEN'(TVEC_RESET);
      sepc          <= '0;
      scause        <= '0;
      redirect_pc_q <= '0;
      redirect_q    <= 1'b0;
    end else begin
      redirect_q <= 1'b0;
      if (csr_we) begin
        case (bus.csr_addr)
          A_SSTATUS: {pie, ie} <= wr_val[1:0];
          A_SIE:     sie       <= wr_val[NUM_IRQ-1:0];
`ifdef VECTORED_TVEC_EN
          A_STVEC:   stvec     <= wr_val;
`else
          A_STVEC:   stvec     <= {wr_val[XLEN-1:2], 2'b00};
`endif
          A_SEPC:    sepc      <= wr_val;
          A_SCAUSE:  scause    <= wr_val;
          default:   ;
        endcase
      end
      case (state)
        ST_REDIRECT: state <= ret_flag ? ST_RUN : ST_HANDLER;
        default: begin
          if (sync_trap || irq_take) begin
            if (sync_trap) begin
              sepc   <= bus.ex_pc + XLEN'(4);
              scause <= {1'b0, (XLEN-1)'(bus.ex_cause)};
            end else begin
              sepc   <= bus.ex_pc;
              scause <= {1'b1, (XLEN-1)'(irq_idx) + (XLEN-1)'(16)};
            end
            pie           <= ie;
            ie            <= 1'b0;
            redirect_pc_q <= trap_target;
            ret_flag      <= 1'b0;
            redirect_q    <= 1'b1;
            state         <= ST_REDIRECT;
          end else if (mret_take) begin
            ie            <= pie;
            pie           <= 1'b1;
            redirect_pc_q <= sepc;
            ret_flag      <= 1'b1;
            redirect_q    <= 1'b1;
            state         <= ST_REDIRECT;
          end
        end
      endcase
    end
  end

  assign bus.csr_rdata     = rdata;
  assign bus.kill_ex       = kill;
  assign bus.trap_redirect = redirect_q;
  assign bus.redirect_pc   = redirect_pc_q;
  assign bus.in_handler    = (state == ST_HANDLER);
  assign bus.state_dbg     = state;

endmodule
